// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM bank: one shared frame counter, angles committed at frame end.
// Define SERVO_SLEW_EN to limit each channel's angle change to SLEW_STEP per frame.
`timescale 1ns/1ps
module servo_pwm_bank #(
  parameter int NUM_CH    = 4,
  parameter int ANG_W     = 8,
  parameter int PERIOD    = 2000,
  parameter int PULSE_OFS = 100,
  parameter int RESET_ANG = 128,
  parameter int SLEW_STEP = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = $clog2(PERIOD)
) (
  input  logic              clk_100kHz,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ANG_W-1:0]  wr_angle,
  output logic [NUM_CH-1:0] pwm,
  output logic              frame_tick,
  output logic              err
);

  logic [CNT_W-1:0] cnt;
  logic [ANG_W-1:0] tgt [NUM_CH];
  logic [ANG_W-1:0] cur [NUM_CH];
  logic [ANG_W-1:0] nxt [NUM_CH];
  logic             last;
  logic             accept;
  logic             bad_ch;

  assign last   = cnt == CNT_W'(PERIOD - 1);
  assign accept = wr_valid & wr_ready;
  assign bad_ch = {1'b0, wr_ch} >= (CH_W + 1)'(NUM_CH);

`ifdef SERVO_SLEW_EN
  localparam logic [ANG_W-1:0] STEP = ANG_W'(SLEW_STEP);

  // Step toward the target without ever overshooting it.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      nxt[i] = cur[i];
      if (tgt[i] > cur[i]) begin
        if (tgt[i] - cur[i] > STEP)
          nxt[i] = cur[i] + STEP;
        else
          nxt[i] = tgt[i];
      end else if (tgt[i] < cur[i]) begin
        if (cur[i] - tgt[i] > STEP)
          nxt[i] = cur[i] - STEP;
        else
          nxt[i] = tgt[i];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      nxt[i] = tgt[i];
  end
`endif

  always_ff @(posedge clk_100kHz or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      pwm        <= '0;
      frame_tick <= 1'b0;
      err        <= 1'b0;
      wr_ready   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt[i] <= ANG_W'(RESET_ANG);
        cur[i] <= ANG_W'(RESET_ANG);
      end
    end else begin
      cnt        <= last ? '0 : cnt + 1'b1;
      frame_tick <= last;
      // Ready drops for exactly the commit cycle.
      wr_ready   <= cnt != CNT_W'(PERIOD - 2);
      for (int i = 0; i < NUM_CH; i++)
        pwm[i] <= cnt < CNT_W'(PULSE_OFS) + CNT_W'(cur[i]);
      if (last) begin
        for (int i = 0; i < NUM_CH; i++)
          cur[i] <= nxt[i];
      end
      if (accept) begin
        if (bad_ch)
          err <= 1'b1;
        for (int i = 0; i < NUM_CH; i++)
          if (wr_ch == CH_W'(i))
            tgt[i] <= wr_angle;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Randomized bench for servo_pwm_bank against a per-frame behavioural model.
// Uses a 5-channel build so an out-of-range channel index is reachable.
`timescale 1ns/1ps
module tb_servo_pwm_bank;

  localparam int NUM_CH    = 5;
  localparam int ANG_W     = 8;
  localparam int PERIOD    = 2000;
  localparam int PULSE_OFS = 100;
  localparam int RESET_ANG = 128;
  localparam int SLEW_STEP = 4;
  localparam int CH_W      = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [CH_W-1:0]   wr_ch = '0;
  logic [ANG_W-1:0]  wr_angle = '0;
  logic [NUM_CH-1:0] pwm;
  logic              frame_tick;
  logic              err;

  servo_pwm_bank #(
    .NUM_CH(NUM_CH), .ANG_W(ANG_W), .PERIOD(PERIOD),
    .PULSE_OFS(PULSE_OFS), .RESET_ANG(RESET_ANG),
    .SLEW_STEP(SLEW_STEP)
  ) dut (
    .clk_100kHz(clk),
    .rst(rst),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_ch(wr_ch),
    .wr_angle(wr_angle),
    .pwm(pwm),
    .frame_tick(frame_tick),
    .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Model state: angles per frame, sticky error, cycles since release.
  int cur_m [NUM_CH];
  int tgt_m [NUM_CH];
  bit err_m;
  int k;
  bit pend;
  int pch;
  int pang;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      cur_m[i] = RESET_ANG;
      tgt_m[i] = RESET_ANG;
    end
    err_m = 1'b0;
    k     = 0;
    pend  = 1'b0;
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef SERVO_SLEW_EN
      int d;
      d = tgt_m[i] - cur_m[i];
      if (d > SLEW_STEP)
        cur_m[i] += SLEW_STEP;
      else if (d < -SLEW_STEP)
        cur_m[i] -= SLEW_STEP;
      else
        cur_m[i] = tgt_m[i];
`else
      cur_m[i] = tgt_m[i];
`endif
    end
  endfunction

  initial begin
    int n;
    int c;
    int f;
    bit rdy;
    bit did_rst;
    logic [NUM_CH-1:0] exp_pwm;

    n = 0;
    did_rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_pwm", 32'(pwm), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    chk("rst_ready", 32'(wr_ready), 0);
    chk("rst_err", 32'(err), 0);
    model_reset();
    rst = 1'b0;
    #1;

    while (n < 21000) begin
      c = k % PERIOD;
      f = k / PERIOD;
      if (k > 0 && c == 0)
        model_commit();
      exp_pwm = '0;
      for (int i = 0; i < NUM_CH; i++)
        if (c >= 1 && c <= PULSE_OFS + cur_m[i])
          exp_pwm[i] = 1'b1;
      rdy = (k > 0) && (c != PERIOD - 1);
      chk("pwm", 32'(pwm), 32'(exp_pwm));
      chk("frame_tick", 32'(frame_tick),
          32'((k > 0) && (c == 0)));
      chk("wr_ready", 32'(wr_ready), 32'(rdy));
      chk("err", 32'(err), 32'(err_m));

      if (!did_rst && f == 7 && c == 150) begin
        rst = 1'b1;
        wr_valid = 1'b0;
        #1;
        chk("midrst_pwm", 32'(pwm), 0);
        chk("midrst_tick", 32'(frame_tick), 0);
        chk("midrst_ready", 32'(wr_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        did_rst = 1'b1;
        #1;
        n++;
        continue;
      end

      if (!pend) begin
        if (!did_rst) begin
          if (f == 1 && c == 500) begin
            pend = 1; pch = 2; pang = 0;
          end else if (f == 1 && c == 600) begin
            pend = 1; pch = 1; pang = 255;
          end else if (f == 1 && c == 601) begin
            pend = 1; pch = 1; pang = 10;
          end else if (f == 2 && c == PERIOD - 1) begin
            pend = 1; pch = 3; pang = 50;
          end else if (f == 3 && c == 100) begin
            pend = 1; pch = 5; pang = 77;
          end else if (f == 3 && c == PERIOD - 2) begin
            pend = 1; pch = 0; pang = 140;
          end
        end
        if (!pend && (f >= 4 || did_rst) &&
            $urandom_range(0, 199) == 0) begin
          pend = 1;
          pch  = int'($urandom_range(0, 7));
          pang = int'($urandom_range(0, 255));
        end
      end

      wr_valid = pend;
      wr_ch    = CH_W'(pch);
      wr_angle = ANG_W'(pang);
      if (pend && rdy) begin
        if (pch >= NUM_CH)
          err_m = 1'b1;
        else
          tgt_m[pch] = pang;
        pend = 1'b0;
      end

      @(posedge clk);
      k++;
      n++;
      @(negedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
